fir_mac_seq: RTL and testbench

- Parametrised successor to the 16-tap moving-sum filter. It is a TAPS-tap FIR with runtime-programmable unsigned coefficients and one time-shared multiplier (one MAC per clock).
- Adds a valid/ready input handshake, an output valid strobe, a rounding right-shift, and saturation.
- Sits between the switch/sample source and the LED/display sink.
- With default coefficients (all 1) and SHIFT=0 it computes the same 16-sample sum, except the result saturates instead of wrapping.

---
 rtl/fir_mac_seq_if.sv | 30 +++
 rtl/fir_mac_seq.sv | 91 +++++++++
 tb/tb_fir_mac_seq.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_seq_if.sv
// rtl/fir_mac_seq_if.sv - sample, coefficient and result signals of the sequential FIR
interface fir_mac_seq_if #(
  parameter int DATA_W = 10,
  parameter int COEF_W = 8,
  parameter int TAPS   = 16,
  parameter int OUT_W  = 10
);
  localparam int ADDR_W = $clog2(TAPS);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              coef_we;
  logic [ADDR_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_sat;
  logic              busy;

  modport master (
    output in_data, in_valid, coef_we, coef_addr, coef_data,
    input  in_ready, out_data, out_valid, out_sat, busy
  );

  modport slave (
    input  in_data, in_valid, coef_we, coef_addr, coef_data,
    output in_ready, out_data, out_valid, out_sat, busy
  );
endinterface

// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - TAPS-tap FIR, one time-shared MAC per clock, rounding shift and saturation
module fir_mac_seq #(
  parameter int DATA_W = 10,
  parameter int COEF_W = 8,
  parameter int TAPS   = 16,
  parameter int OUT_W  = 10,
  parameter int SHIFT  = 0
) (
  input logic          CLOCK_50,
  input logic          KEY0,
  fir_mac_seq_if.slave bus
);
  localparam int ADDR_W = $clog2(TAPS);
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int RND_W  = ACC_W + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [RND_W-1:0] RND = (SHIFT > 0) ? (RND_W'(1) << RND_SH) : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] dly  [TAPS];
  logic [COEF_W-1:0] coef [TAPS];
  logic [ACC_W-1:0]  acc;
  logic [ADDR_W-1:0] k;
  logic [ACC_W-1:0]  prod;
  logic [RND_W-1:0]  rounded;
  logic [RND_W-1:0]  shifted;
  logic              sat;
  logic              accept;
  logic              coef_wr;

  // in_ready is gated by KEY0 so the source sees 0 for the whole reset pulse
  assign bus.in_ready = KEY0 && (state == S_IDLE);
  assign bus.busy     = (state != S_IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign coef_wr      = (state == S_IDLE) && bus.coef_we &&
                        ({1'b0, bus.coef_addr} < (ADDR_W + 1)'(TAPS));

  assign prod = ACC_W'(dly[k]) * ACC_W'(coef[k]);

  always_comb begin
    rounded = {1'b0, acc} + RND;
    shifted = rounded >> SHIFT;
    sat     = |(shifted >> OUT_W);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      state         <= S_IDLE;
      acc           <= '0;
      k             <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sat   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        dly[i]  <= '0;
        coef[i] <= COEF_W'(1);
      end
    end else begin
      bus.out_valid <= 1'b0;
      // a same-edge sample sees this coefficient, since MAC starts one edge later
      if (coef_wr) coef[bus.coef_addr] <= bus.coef_data;
      case (state)
        S_IDLE: begin
          if (accept) begin
            dly[0] <= bus.in_data;
            for (int i = 1; i < TAPS; i++) dly[i] <= dly[i-1];
            acc   <= '0;
            k     <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod;
          k   <= k + 1'b1;
          if (k == ADDR_W'(TAPS - 1)) state <= S_DONE;
        end
        S_DONE: begin
          bus.out_data  <= sat ? '1 : OUT_W'(shifted);
          bus.out_sat   <= sat;
          bus.out_valid <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb/tb_fir_mac_seq.sv - randomized self-checking bench for fir_mac_seq against a convolution model
module tb_fir_mac_seq;
  localparam int DATA_W = 10;
  localparam int COEF_W = 8;
  localparam int TAPS   = 16;
  localparam int OUT_W  = 10;
  localparam int MAXV   = (1 << OUT_W) - 1;
  localparam int MAXD   = (1 << DATA_W) - 1;
  localparam int MAXC   = (1 << COEF_W) - 1;
  localparam int LAT    = TAPS + 2;

  logic CLOCK_50 = 1'b0;
  logic KEY0;
  always #5 CLOCK_50 = ~CLOCK_50;

  fir_mac_seq_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) bus ();
  fir_mac_seq_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) bus2 ();

  fir_mac_seq #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(0))
    dut (.CLOCK_50(CLOCK_50), .KEY0(KEY0), .bus(bus));
  fir_mac_seq #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(2))
    dut2 (.CLOCK_50(CLOCK_50), .KEY0(KEY0), .bus(bus2));

  int n_pass = 0;
  int n_total = 0;
  int m_coef [TAPS];
  int ones [TAPS];
  int hist1 [$];
  int hist2 [$];
  int stim_q [$];
  int exp_q [$];
  int res_q [$];
  int lat_q [$];
  int rdy_q [$];
  bit expsat_q [$];
  bit sat_q [$];
  int dbl;

  // y = sum_j x[n-j]*c[j] over samples accepted since reset, then round, shift, clamp
  function automatic void ref_fir(input int hs[$], input int cf[TAPS], input int shift,
                                  output int r, output bit s);
    longint acc;
    int n;
    acc = 0;
    n = hs.size();
    for (int j = 0; j < TAPS && j < n; j++) acc += longint'(hs[n-1-j]) * longint'(cf[j]);
    if (shift > 0) acc = (acc + (longint'(1) << (shift - 1))) >> shift;
    s = (acc > MAXV);
    r = s ? MAXV : int'(acc);
  endfunction

  task automatic model_reset();
    hist1.delete();
    hist2.delete();
    for (int j = 0; j < TAPS; j++) m_coef[j] = 1;
  endtask

  task automatic do_reset(input int n);
    KEY0 = 1'b0;
    repeat (n) @(negedge CLOCK_50);
    KEY0 = 1'b1;
    model_reset();
  endtask

  task automatic write_coef(input int addr, input int data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'(addr);
    bus.coef_data = 8'(data);
    @(negedge CLOCK_50);
    bus.coef_we   = 1'b0;
    m_coef[addr]  = data;
  endtask

  task automatic wait_out(input int which, output int r, output bit s, output int cyc);
    cyc = -1;
    r = -1;
    s = 1'b0;
    for (int i = 1; i <= LAT * 3; i++) begin
      @(negedge CLOCK_50);
      if (which == 1 ? bus.out_valid : bus2.out_valid) begin
        cyc = i;
        r = (which == 1) ? int'(bus.out_data) : int'(bus2.out_data);
        s = (which == 1) ? bus.out_sat : bus2.out_sat;
        break;
      end
    end
  endtask

  task automatic send2(input int data, output int r, output bit s, output int cyc);
    for (int i = 0; i < 50 && !bus2.in_ready; i++) @(negedge CLOCK_50);
    bus2.in_data  = 10'(data);
    bus2.in_valid = 1'b1;
    @(negedge CLOCK_50);
    bus2.in_valid = 1'b0;
    hist2.push_back(data);
    wait_out(2, r, s, cyc);
  endtask

  task automatic run1(input int n_res, input bit rand_data, input bit rand_valid, output bit timeout);
    int cyc;
    int acc_cyc [$];
    bit prev_v;
    int r;
    bit s;
    cyc = 0; prev_v = 1'b0; timeout = 1'b0; dbl = 0;
    res_q.delete(); sat_q.delete(); lat_q.delete(); rdy_q.delete(); exp_q.delete(); expsat_q.delete();
    while (res_q.size() < n_res) begin
      if (rand_data) begin
        bus.in_data  = 10'($urandom_range(0, MAXD));
        bus.in_valid = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
      end else begin
        bus.in_data  = (stim_q.size() > 0) ? 10'(stim_q[0]) : '0;
        bus.in_valid = (stim_q.size() > 0) && (!rand_valid || $urandom_range(0, 1) == 1);
      end
      #1;
      if (bus.in_valid && bus.in_ready) begin
        hist1.push_back(int'(bus.in_data));
        ref_fir(hist1, m_coef, 0, r, s);
        exp_q.push_back(r);
        expsat_q.push_back(s);
        acc_cyc.push_back(cyc);
        if (!rand_data) void'(stim_q.pop_front());
      end
      @(negedge CLOCK_50);
      cyc++;
      if (bus.out_valid) begin
        res_q.push_back(int'(bus.out_data));
        sat_q.push_back(bus.out_sat);
        rdy_q.push_back(int'(bus.in_ready));
        if (acc_cyc.size() > 0) lat_q.push_back(cyc - acc_cyc.pop_front());
        else lat_q.push_back(-1);
        if (prev_v) dbl++;
      end
      prev_v = bus.out_valid;
      if (cyc > n_res * LAT * 4 + 100) begin
        timeout = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    KEY0 = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_data !== 10'd0) $display("FAIL reset_out_data got %0d exp 0", bus.out_data); else n_pass++;
    n_total++; if (bus.out_sat !== 1'b0) $display("FAIL reset_out_sat got %b exp 0", bus.out_sat); else n_pass++;
    KEY0 = 1'b1;
    model_reset();
    #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_steady();
    bit to;
    stim_q.delete();
    for (int i = 0; i < 12; i++) stim_q.push_back(100);
    run1(12, 1'b0, 1'b0, to);
    n_total++; if (to !== 1'b0) $display("FAIL steady_timeout got %0d results exp 12", res_q.size()); else n_pass++;
    for (int i = 0; i < res_q.size(); i++) begin
      n_total++; if (res_q[i] !== ((i < 10) ? 100 * (i + 1) : MAXV)) $display("FAIL steady_data[%0d] got %0d exp %0d", i, res_q[i], (i < 10) ? 100 * (i + 1) : MAXV); else n_pass++;
      n_total++; if (sat_q[i] !== (i >= 10)) $display("FAIL steady_sat[%0d] got %b exp %b", i, sat_q[i], i >= 10); else n_pass++;
      n_total++; if (lat_q[i] !== LAT) $display("FAIL steady_latency[%0d] got %0d exp %0d", i, lat_q[i], LAT); else n_pass++;
      n_total++; if (rdy_q[i] !== 1) $display("FAIL steady_ready_at_valid[%0d] got %0d exp 1", i, rdy_q[i]); else n_pass++;
    end
    n_total++; if (dbl !== 0) $display("FAIL steady_double_valid got %0d exp 0", dbl); else n_pass++;
  endtask

  task automatic test_impulse();
    bit to;
    do_reset(2);
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
    stim_q.delete();
    stim_q.push_back(1);
    for (int i = 0; i < 20; i++) stim_q.push_back(0);
    run1(21, 1'b0, 1'b0, to);
    n_total++; if (to !== 1'b0) $display("FAIL impulse_timeout got %0d results exp 21", res_q.size()); else n_pass++;
    for (int i = 0; i < res_q.size(); i++) begin
      n_total++; if (res_q[i] !== ((i < TAPS) ? i + 1 : 0)) $display("FAIL impulse_data[%0d] got %0d exp %0d", i, res_q[i], (i < TAPS) ? i + 1 : 0); else n_pass++;
    end
  endtask

  task automatic test_handshake();
    bit to;
    do_reset(2);
    run1(6, 1'b1, 1'b0, to);
    n_total++; if (to !== 1'b0) $display("FAIL handshake_timeout got %0d results exp 6", res_q.size()); else n_pass++;
    for (int i = 0; i < res_q.size(); i++) begin
      n_total++; if (res_q[i] !== exp_q[i]) $display("FAIL handshake_data[%0d] got %0d exp %0d", i, res_q[i], exp_q[i]); else n_pass++;
      n_total++; if (lat_q[i] !== LAT) $display("FAIL handshake_latency[%0d] got %0d exp %0d", i, lat_q[i], LAT); else n_pass++;
    end
    n_total++; if (dbl !== 0) $display("FAIL handshake_double_valid got %0d exp 0", dbl); else n_pass++;
  endtask

  task automatic test_random_coef();
    bit to;
    do_reset(2);
    for (int i = 0; i < TAPS; i++) write_coef(i, $urandom_range(0, MAXC));
    run1(8, 1'b1, 1'b1, to);
    n_total++; if (to !== 1'b0) $display("FAIL randcoef_timeout got %0d results exp 8", res_q.size()); else n_pass++;
    for (int i = 0; i < res_q.size(); i++) begin
      n_total++; if (res_q[i] !== exp_q[i]) $display("FAIL randcoef_data[%0d] got %0d exp %0d", i, res_q[i], exp_q[i]); else n_pass++;
      n_total++; if (sat_q[i] !== expsat_q[i]) $display("FAIL randcoef_sat[%0d] got %b exp %b", i, sat_q[i], expsat_q[i]); else n_pass++;
    end
    n_total++; if (dbl !== 0) $display("FAIL randcoef_double_valid got %0d exp 0", dbl); else n_pass++;
  endtask

  task automatic test_blocked_write();
    int r;
    bit s;
    int c;
    do_reset(2);
    bus.in_data = 10'd1;
    bus.in_valid = 1'b1;
    @(negedge CLOCK_50);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    n_total++; if (bus.busy !== 1'b1) $display("FAIL blocked_busy got %b exp 1", bus.busy); else n_pass++;
    write_coef(0, 5);
    m_coef[0] = 1;
    wait_out(1, r, s, c);
    n_total++; if (r !== 1) $display("FAIL blocked_write_data got %0d exp 1", r); else n_pass++;
    do_reset(1);
    bus.coef_we = 1'b1;
    bus.coef_addr = 4'd0;
    bus.coef_data = 8'd5;
    bus.in_data = 10'd1;
    bus.in_valid = 1'b1;
    @(negedge CLOCK_50);
    bus.coef_we = 1'b0;
    bus.in_valid = 1'b0;
    wait_out(1, r, s, c);
    n_total++; if (r !== 5) $display("FAIL same_edge_write_data got %0d exp 5", r); else n_pass++;
    n_total++; if (c !== TAPS + 1) $display("FAIL same_edge_latency got %0d exp %0d", c, TAPS + 1); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int cnt;
    bit to;
    do_reset(2);
    write_coef(0, 3);
    bus.in_data = 10'd77;
    bus.in_valid = 1'b1;
    @(negedge CLOCK_50);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge CLOCK_50);
    KEY0 = 1'b0;
    #1;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL midreset_in_ready got %b exp 0", bus.in_ready); else n_pass++;
    @(negedge CLOCK_50);
    KEY0 = 1'b1;
    model_reset();
    cnt = 0;
    repeat (LAT * 2) begin
      @(negedge CLOCK_50);
      if (bus.out_valid) cnt++;
    end
    n_total++; if (cnt !== 0) $display("FAIL midreset_no_valid got %0d strobes exp 0", cnt); else n_pass++;
    n_total++; if (bus.out_data !== 10'd0) $display("FAIL midreset_out_data got %0d exp 0", bus.out_data); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL midreset_busy got %b exp 0", bus.busy); else n_pass++;
    stim_q.delete();
    stim_q.push_back(50);
    run1(1, 1'b0, 1'b0, to);
    n_total++; if (to !== 1'b0) $display("FAIL midreset_timeout got %0d results exp 1", res_q.size()); else n_pass++;
    n_total++; if (res_q.size() < 1 || res_q[0] !== 50) $display("FAIL midreset_after_data got %0d exp 50", (res_q.size() > 0) ? res_q[0] : -1); else n_pass++;
  endtask

  task automatic test_round();
    int r;
    bit s;
    int c;
    int er;
    bit es;
    int v;
    do_reset(2);
    send2(3, r, s, c);
    n_total++; if (r !== 1) $display("FAIL round_first got %0d exp 1", r); else n_pass++;
    n_total++; if (c !== TAPS + 1) $display("FAIL round_latency got %0d exp %0d", c, TAPS + 1); else n_pass++;
    send2(3, r, s, c);
    n_total++; if (r !== 2) $display("FAIL round_second got %0d exp 2", r); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      v = $urandom_range(0, MAXD);
      send2(v, r, s, c);
      ref_fir(hist2, ones, 2, er, es);
      n_total++; if (r !== er) $display("FAIL round_rand_data[%0d] got %0d exp %0d", i, r, er); else n_pass++;
      n_total++; if (s !== es) $display("FAIL round_rand_sat[%0d] got %b exp %b", i, s, es); else n_pass++;
    end
  endtask

  initial begin
    KEY0 = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    bus2.in_data = '0; bus2.in_valid = 1'b0; bus2.coef_we = 1'b0; bus2.coef_addr = '0; bus2.coef_data = '0;
    for (int j = 0; j < TAPS; j++) ones[j] = 1;
    model_reset();
    test_reset();
    test_steady();
    test_impulse();
    test_handshake();
    test_random_coef();
    test_blocked_write();
    test_mid_reset();
    test_round();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", n_total);
    $fatal(1, "watchdog");
  end
endmodule
